// File: rtl/snake_game_sequencer_if.sv
// Game-flow bus between the snake sequencer and its debouncer, frame timing,
// board logic and score display.
interface snake_game_sequencer_if;
    logic        start_pulse;
    logic        frame_start;
    logic        food_eaten;
    logic        collision;
    logic        move_tick;
    logic        clear_board;
    logic [1:0]  state;
    logic [15:0] score;
    logic [2:0]  level;

    // Sequencer side: consumes event pulses, produces commands and display data.
    modport master (
        input  start_pulse, frame_start, food_eaten, collision,
        output move_tick, clear_board, state, score, level
    );

    // Environment side: board, debouncer, frame timing and display.
    modport slave (
        output start_pulse, frame_start, food_eaten, collision,
        input  move_tick, clear_board, state, score, level
    );
endinterface

// File: rtl/snake_game_sequencer.sv
// Snake game flow: idle/play/pause/dead phases, frame-paced moves, BCD score and level.
// Latency: every output is registered, 1 cycle after the causing input pulse.
// Backpressure: none; single-cycle event pulses are consumed every cycle.
module snake_game_sequencer #(
    parameter int FRAMES_PER_MOVE_INIT = 8,
    parameter int FRAMES_PER_MOVE_MIN  = 2,
    parameter int POINTS_PER_LEVEL     = 5,
    parameter int DEATH_HOLD_FRAMES    = 120
) (
    input logic                   clk,
    input logic                   reset_n,
    snake_game_sequencer_if.master bus
);
    localparam int PW = $clog2(POINTS_PER_LEVEL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b11,
        DEAD  = 2'b10
    } state_t;

    state_t         state_q, state_nxt;
    logic [4:0]     frame_cnt, frame_cnt_nxt;
    logic [PW-1:0]  point_cnt, point_cnt_nxt;
    logic [6:0]     hold_cnt, hold_cnt_nxt;
    logic [15:0]    score_q, score_nxt;
    logic [2:0]     level_q, level_nxt;
    logic           tick_nxt, clear_nxt;
    logic           move_tick_q, clear_board_q;
    logic [5:0]     period, period_m1;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // period = max(INIT - level, MIN), evaluated on the current registered level
    always_comb begin
        if (6'(FRAMES_PER_MOVE_INIT) >= {3'b000, level_q} + 6'(FRAMES_PER_MOVE_MIN))
            period = 6'(FRAMES_PER_MOVE_INIT) - {3'b000, level_q};
        else
            period = 6'(FRAMES_PER_MOVE_MIN);
        period_m1 = period - 6'd1;
    end

    always_comb begin
        state_nxt     = state_q;
        frame_cnt_nxt = frame_cnt;
        point_cnt_nxt = point_cnt;
        hold_cnt_nxt  = hold_cnt;
        score_nxt     = score_q;
        level_nxt     = level_q;
        tick_nxt      = 1'b0;
        clear_nxt     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_pulse) begin
                    state_nxt     = PLAY;
                    clear_nxt     = 1'b1;
                    score_nxt     = 16'h0000;
                    level_nxt     = 3'd0;
                    frame_cnt_nxt = 5'd0;
                    point_cnt_nxt = '0;
                    hold_cnt_nxt  = 7'd0;
                end
            end
            PLAY: begin
                if (bus.collision) begin
                    state_nxt     = DEAD;
                    frame_cnt_nxt = 5'd0;
                    hold_cnt_nxt  = 7'd0;
                end else begin
                    // A pause request swallows a coincident frame so the count is not advanced
                    if (bus.start_pulse) begin
                        state_nxt = PAUSE;
                    end else if (bus.frame_start) begin
                        if ({1'b0, frame_cnt} >= period_m1) begin
                            frame_cnt_nxt = 5'd0;
                            tick_nxt      = 1'b1;
                        end else begin
                            frame_cnt_nxt = frame_cnt + 5'd1;
                        end
                    end
                    if (bus.food_eaten) begin
                        if (score_q != 16'h9999)
                            score_nxt = bcd_inc(score_q);
                        if (point_cnt == PW'(POINTS_PER_LEVEL - 1)) begin
                            point_cnt_nxt = '0;
                            if (level_q != 3'd7)
                                level_nxt = level_q + 3'd1;
                        end else begin
                            point_cnt_nxt = point_cnt + PW'(1);
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.start_pulse)
                    state_nxt = PLAY;
            end
            DEAD: begin
                if (bus.frame_start) begin
                    if (hold_cnt == 7'(DEATH_HOLD_FRAMES - 1)) begin
                        state_nxt    = IDLE;
                        hold_cnt_nxt = 7'd0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 7'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            frame_cnt     <= 5'd0;
            point_cnt     <= '0;
            hold_cnt      <= 7'd0;
            score_q       <= 16'h0000;
            level_q       <= 3'd0;
            move_tick_q   <= 1'b0;
            clear_board_q <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            frame_cnt     <= frame_cnt_nxt;
            point_cnt     <= point_cnt_nxt;
            hold_cnt      <= hold_cnt_nxt;
            score_q       <= score_nxt;
            level_q       <= level_nxt;
            move_tick_q   <= tick_nxt;
            clear_board_q <= clear_nxt;
        end
    end

    assign bus.state       = state_q;
    assign bus.score       = score_q;
    assign bus.level       = level_q;
    assign bus.move_tick   = move_tick_q;
    assign bus.clear_board = clear_board_q;
endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed bench for snake_game_sequencer: pacing, pause, scoring, saturation,
// collision priority, death hold and resets.
module tb_snake_game_sequencer;
    logic clk;
    logic reset_n;
    int   n_chk, n_pass, n_fail;
    int   tick_cnt, clear_cnt;

    snake_game_sequencer_if bus ();

    snake_game_sequencer #(
        .FRAMES_PER_MOVE_INIT (8),
        .FRAMES_PER_MOVE_MIN  (2),
        .POINTS_PER_LEVEL     (5),
        .DEATH_HOLD_FRAMES    (120)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.move_tick === 1'b1)   tick_cnt++;
        if (bus.clear_board === 1'b1) clear_cnt++;
    endtask

    task automatic pulse_start();
        bus.start_pulse = 1'b1; cyc(); bus.start_pulse = 1'b0;
    endtask

    task automatic pulse_food();
        bus.food_eaten = 1'b1; cyc(); bus.food_eaten = 1'b0;
    endtask

    // One frame pulse; move_tick is visible on return, then two quiet cycles.
    task automatic frame(input string tag, input logic exp_tick);
        bus.frame_start = 1'b1; cyc(); bus.frame_start = 1'b0;
        check(tag, 32'(bus.move_tick), 32'(exp_tick));
        cyc(); cyc();
    endtask

    task automatic frames_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_start = 1'b1; cyc(); bus.frame_start = 1'b0; cyc();
        end
    endtask

    initial begin
        int t0;
        n_chk = 0; n_pass = 0; n_fail = 0; tick_cnt = 0; clear_cnt = 0;
        bus.start_pulse = 1'b0; bus.frame_start = 1'b0;
        bus.food_eaten  = 1'b0; bus.collision   = 1'b0;
        reset_n = 1'b0;
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();
        check("rst_state", 32'(bus.state), 32'h0);
        check("rst_score", 32'(bus.score), 32'h0);
        check("rst_level", 32'(bus.level), 32'h0);
        check("rst_tick",  32'(bus.move_tick), 32'h0);
        check("rst_clear", 32'(bus.clear_board), 32'h0);

        // Collision in IDLE is ignored
        bus.collision = 1'b1; cyc(); bus.collision = 1'b0;
        check("idle_coll_state", 32'(bus.state), 32'h0);

        // Start and level-0 pacing
        tick_cnt = 0; clear_cnt = 0;
        pulse_start();
        check("start_state", 32'(bus.state), 32'h1);
        check("start_clear", 32'(bus.clear_board), 32'h1);
        for (int i = 1; i <= 24; i++)
            frame($sformatf("pace_f%0d", i), (i % 8) == 0);
        check("pace_ticks", 32'(tick_cnt), 32'd3);
        check("pace_clears", 32'(clear_cnt), 32'd1);

        // Pause freezes pacing and scoring
        frames_quiet(3);
        pulse_start();
        check("pause_state", 32'(bus.state), 32'h3);
        t0 = tick_cnt;
        frames_quiet(20);
        pulse_food();
        check("pause_ticks", 32'(tick_cnt - t0), 32'd0);
        check("pause_score", 32'(bus.score), 32'h0);
        pulse_start();
        check("resume_state", 32'(bus.state), 32'h1);
        for (int i = 1; i <= 5; i++)
            frame($sformatf("resume_f%0d", i), i == 5);

        // Scoring and level ramp: 10 food gives level 2, period 6
        for (int i = 0; i < 10; i++) begin
            pulse_food(); cyc();
        end
        check("score_10", 32'(bus.score), 32'h0010);
        check("level_2", 32'(bus.level), 32'd2);
        for (int i = 1; i <= 6; i++)
            frame($sformatf("lvl2_f%0d", i), i == 6);

        // Collision beats a coincident food and qualifying frame
        for (int i = 1; i <= 5; i++)
            frame($sformatf("pre_coll_f%0d", i), 1'b0);
        bus.collision = 1'b1; bus.food_eaten = 1'b1; bus.frame_start = 1'b1;
        cyc();
        bus.collision = 1'b0; bus.food_eaten = 1'b0; bus.frame_start = 1'b0;
        check("coll_state", 32'(bus.state), 32'h2);
        check("coll_score", 32'(bus.score), 32'h0010);
        check("coll_tick",  32'(bus.move_tick), 32'h0);
        cyc();
        check("coll_tick_late", 32'(bus.move_tick), 32'h0);
        pulse_start();
        check("dead_start_ign", 32'(bus.state), 32'h2);

        // Death hold: 119 frames still dead, the 120th returns to IDLE
        frames_quiet(119);
        check("dead_119", 32'(bus.state), 32'h2);
        frames_quiet(1);
        check("dead_120", 32'(bus.state), 32'h0);
        check("idle_score_held", 32'(bus.score), 32'h0010);
        check("idle_level_held", 32'(bus.level), 32'd2);

        // New game, then drive the score to saturation
        pulse_start();
        check("new_score", 32'(bus.score), 32'h0);
        check("new_level", 32'(bus.level), 32'd0);
        bus.food_eaten = 1'b1;
        repeat (9999) cyc();
        bus.food_eaten = 1'b0;
        cyc();
        check("score_9999", 32'(bus.score), 32'h9999);
        check("level_sat", 32'(bus.level), 32'd7);
        pulse_food();
        check("score_sat", 32'(bus.score), 32'h9999);

        // Level 7 uses the floor period of 2; reset while move_tick is high
        frame("l7_f1", 1'b0);
        bus.frame_start = 1'b1; cyc(); bus.frame_start = 1'b0;
        check("l7_tick", 32'(bus.move_tick), 32'h1);
        reset_n = 1'b0; cyc();
        check("midrst_state", 32'(bus.state), 32'h0);
        check("midrst_score", 32'(bus.score), 32'h0);
        check("midrst_level", 32'(bus.level), 32'h0);
        check("midrst_tick",  32'(bus.move_tick), 32'h0);
        reset_n = 1'b1; cyc();

        // Reset while in DEAD part-way through the hold
        pulse_start();
        bus.collision = 1'b1; cyc(); bus.collision = 1'b0;
        frames_quiet(10);
        check("dead2_state", 32'(bus.state), 32'h2);
        reset_n = 1'b0; cyc();
        check("deadrst_state", 32'(bus.state), 32'h0);
        check("deadrst_clear", 32'(bus.clear_board), 32'h0);
        reset_n = 1'b1; cyc();

        // Counters are clear after reset: first tick on the 8th frame again
        pulse_start();
        for (int i = 1; i <= 8; i++)
            frame($sformatf("post_rst_f%0d", i), i == 8);

        // Pause request with a coincident frame drops that frame
        frames_quiet(6);
        bus.start_pulse = 1'b1; bus.frame_start = 1'b1; cyc();
        bus.start_pulse = 1'b0; bus.frame_start = 1'b0;
        check("pause_frame_tick", 32'(bus.move_tick), 32'h0);
        pulse_start();
        frame("pause_frame_f7", 1'b0);
        frame("pause_frame_f8", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/snake_game_sequencer.md
# snake_game_sequencer

Top-level game-flow controller for the VGA snake game. It sits between the button debouncer, the display controller and the snake/board renderer. It sequences the game through idle, play, pause and death phases, and paces snake movement in whole video frames. It also owns the 4-digit BCD score and speed level that feed the 7-segment counter display.

## Interface
Parameters:
- FRAMES_PER_MOVE_INIT, 8: frames between snake moves at level 0.
- FRAMES_PER_MOVE_MIN, 2: fastest pacing (floor of the period).
- POINTS_PER_LEVEL, 5: food items per level increment.
- DEATH_HOLD_FRAMES, 120: frames spent in DEAD before returning to IDLE.

Ports:
- clk, in, 1: system clock; sole clock domain.
- reset_n, in, 1: synchronous, active-low reset.
- start_pulse, in, 1: single-cycle debounced button event (debouncer SCEN).
- frame_start, in, 1: single-cycle pulse, once per frame at vCount wrap.
- food_eaten, in, 1: single-cycle pulse from board logic.
- collision, in, 1: single-cycle pulse from board logic.
- move_tick, out, 1: single-cycle command to advance the snake one cell.
- clear_board, out, 1: single-cycle command to reinitialise the board.
- state, out, 2: 00 IDLE, 01 PLAY, 11 PAUSE, 10 DEAD.
- score, out, 16: BCD {thousands, hundreds, tens, ones}.
- level, out, 3: current speed level, 0–7.

## Operation
- The FSM uses the same encoding as `state`. All transitions are evaluated on the `clk` edge.
- **IDLE**
  - `score` and `level` hold their last values.
  - `start_pulse` → PLAY.
  - On that transition: `clear_board` = 1 for one cycle; `score`, `level`, frame counter and point counter are zeroed.
- **PLAY**
  - Each `frame_start` increments the frame counter (5 bits).
  - period = max(FRAMES_PER_MOVE_INIT − level, FRAMES_PER_MOVE_MIN).
  - If, when `frame_start` arrives, the counter ≥ period − 1:
    - the counter resets to 0;
    - `move_tick` = 1 for the next cycle.
  - The compare is ≥, not ==, so a level increase never skips or stalls a tick.
  - `food_eaten` → BCD score +1, rippling carry through digits. The score saturates at 9999: no wrap, no further change.
  - `food_eaten` also increments the point counter. When it reaches POINTS_PER_LEVEL:
    - the point counter resets to 0;
    - `level` increments, saturating at 7.
  - `start_pulse` → PAUSE.
  - `collision` → DEAD, and the frame counter is cleared.
- **PAUSE**
  - All counters are frozen.
  - `frame_start` and `food_eaten` are ignored; `move_tick` stays 0.
  - `start_pulse` → PLAY with the frame counter preserved.
- **DEAD**
  - `score` and `level` are held for display.
  - `frame_start` increments the hold counter (7 bits).
  - When the count reaches DEATH_HOLD_FRAMES − 1 on a `frame_start` → IDLE, and the hold counter is zeroed.
  - `start_pulse` is ignored.
- **Simultaneous events in PLAY**
  - `collision` has priority: a same-cycle `food_eaten`, `frame_start` tick or `start_pulse` is discarded.
  - `food_eaten` together with `frame_start` (no collision): both are processed. The level change affects the period from the next cycle on.
  - `start_pulse` together with `frame_start`: the transition to PAUSE wins and the frame is not counted.
- `collision` or `food_eaten` outside PLAY: ignored.
- Reset (`reset_n` = 0 on a `clk` edge) in any state, including mid-tick:
  - `state` = IDLE (00);
  - `score` = 0x0000, `level` = 0;
  - `move_tick` = 0, `clear_board` = 0;
  - all internal counters = 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `move_tick` rises exactly 1 cycle after the qualifying `frame_start` cycle and lasts exactly 1 cycle.
- `clear_board` rises 1 cycle after the accepted `start_pulse`, in the same cycle that `state` first reads 01.
- `state`, `score` and `level` update 1 cycle after the causing input.
- Inputs are sampled every cycle; pulses longer than 1 cycle count once per high cycle. Upstream guarantees single-cycle pulses.
- Steady-state tick spacing in PLAY is period × frame_period clocks. At level 0 with default parameters this is 8 frames.
- First tick after entering PLAY: on the 8th `frame_start` at level 0.

## Test plan
- **Reset:** hold `reset_n` low 3 cycles, then release → `state` = 00, `score` = 0x0000, `level` = 0, no pulses.
- **Start and pacing:** `start_pulse`, then 24 `frame_start` pulses → `clear_board` once; exactly 3 `move_tick` pulses, each 1 cycle after the 8th, 16th and 24th `frame_start`.
- **Scoring and levels:** 10 `food_eaten` in PLAY → `score` = 0x0010, `level` = 2, period 6. Preset `score` to 0x9999, then `food_eaten` → stays 0x9999.
- **Pause:** `start_pulse` in PLAY after 3 frames, 20 `frame_start` in PAUSE, then `start_pulse` → no `move_tick` while paused; the next tick arrives after 5 more frames.
- **Collision priority and death hold:** `collision`, `food_eaten` and `frame_start` in the same cycle → `state` = 10, score unchanged, no tick. 120 `frame_start` pulses later → `state` = 00 with score retained.
- **Reset mid-operation:** assert `reset_n` = 0 in the cycle `move_tick` is high, in DEAD → all outputs return to reset values on the next edge.
